// File: rtl/sdram_pixel_unpacker.sv
// -----------------------------------------------------------------------------
// sdram_pixel_unpacker
//
// Read-side partner of the display write packer. On each LCD pixel request
// during an active frame it strobes both SDRAM read FIFOs together. It then
// takes the paired 16-bit words that come back RD_LATENCY cycles later and
// unpacks them into 8-bit R/G/B plus the 8-bit gray byte carried in spare
// bits. One pixel is presented per request, exactly RD_LATENCY+1 cycles after
// that request. The block also tracks the pixel position and FIFO underflows.
//
// Parameters
//   H_ACTIVE       active pixels per line
//   V_ACTIVE       active lines per frame
//   RD_LATENCY     cycles from oRd_Req to valid iRd1_data/iRd2_data (1..3)
//   UNDERFLOW_RGB  {R,G,B} fill colour, used for underflow pixels and view 3
//
// Ports
//   iClk            in   pixel-domain clock, rising edge
//   iRst            in   synchronous reset, active high
//   iFrame_Start    in   1-cycle pulse ahead of the first request of a frame
//   iSelect[1:0]    in   view: 0 RGB, 1 gray, 2 gray-over-RGB, 3 fill colour
//   iDisp_Req       in   LCD asks for one pixel this cycle
//   iRd1_Empty      in   read FIFO 1 empty
//   iRd2_Empty      in   read FIFO 2 empty
//   iRd1_data[15:0] in   {g[7], G[7:3], B[7:0], g[6:5]}
//   iRd2_data[15:0] in   {g[4], G[2:0], g[3:2], R[7:0], g[1:0]}
//   oRd_Req         out  read strobe to both FIFOs (combinational)
//   oR/oG/oB[7:0]   out  selected pixel colour
//   oGray[7:0]      out  recovered gray byte
//   oPix_Valid      out  pixel outputs valid this cycle
//   oX_Cont[10:0]   out  column of the output pixel
//   oY_Cont[9:0]    out  line of the output pixel
//   oUnderflow      out  sticky: an underflow pixel was output in this frame
//   oUnderflow_Cnt  out  saturating underflow count since reset
// -----------------------------------------------------------------------------
module sdram_pixel_unpacker #(
    parameter int          H_ACTIVE      = 800,
    parameter int          V_ACTIVE      = 480,
    parameter int          RD_LATENCY    = 1,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF0000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iFrame_Start,
    input  logic [1:0]  iSelect,
    input  logic        iDisp_Req,
    input  logic        iRd1_Empty,
    input  logic        iRd2_Empty,
    input  logic [15:0] iRd1_data,
    input  logic [15:0] iRd2_data,
    output logic        oRd_Req,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic [7:0]  oGray,
    output logic        oPix_Valid,
    output logic [10:0] oX_Cont,
    output logic [9:0]  oY_Cont,
    output logic        oUnderflow,
    output logic [15:0] oUnderflow_Cnt
);

    // FSM encoding
    localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
    localparam logic [1:0] ST_ACTIVE     = 2'd1;
    localparam logic [1:0] ST_DRAIN      = 2'd2;

    // View encoding
    localparam logic [1:0] VIEW_RGB     = 2'd0;
    localparam logic [1:0] VIEW_GRAY    = 2'd1;
    localparam logic [1:0] VIEW_OVERLAY = 2'd2;

    localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Per-request tag travelling alongside the FIFO read latency.
    //   vld : a request was made (every request yields one pixel)
    //   rd  : both FIFOs were read; data arrives with this tag
    //   uf  : active-frame request that found a FIFO empty
    //   Neither rd nor uf: request outside the active frame (black pixel).
    // The view travels with the pixel so that in-flight pixels of an aborted
    // frame keep the view of the frame they belong to.
    typedef struct packed {
        logic        vld;
        logic        rd;
        logic        uf;
        logic [1:0]  view;
        logic [10:0] x;
        logic [9:0]  y;
    } tag_t;

    // State and position
    logic [1:0]  r_state;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic [1:0]  r_sel;

    // Latency pipeline
    tag_t        r_pipe [RD_LATENCY];

    // Output registers
    logic        r_pix_valid;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;
    logic [7:0]  r_gray;
    logic [10:0] r_x_out;
    logic [9:0]  r_y_out;
    logic        r_underflow;
    logic [15:0] r_uf_cnt;

    // Combinational
    logic        w_active;
    logic        w_fifo_ok;
    logic        w_act_req;
    logic        w_rd;
    logic        w_uf;
    logic        w_last_pix;
    logic        w_pipe_busy;
    tag_t        w_in;
    tag_t        w_out;
    logic [7:0]  w_r;
    logic [7:0]  w_g;
    logic [7:0]  w_b;
    logic [7:0]  w_gray;
    logic [23:0] w_pix_rgb;
    logic [7:0]  w_pix_gray;

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    assign w_active  = (r_state == ST_ACTIVE);
    assign w_fifo_ok = !iRd1_Empty && !iRd2_Empty;
    assign w_act_req = !iRst && w_active && iDisp_Req;

    // Both FIFOs are always read together so the word pair never slips.
    assign w_rd    = w_act_req && w_fifo_ok;
    assign w_uf    = w_act_req && !w_fifo_ok;
    assign oRd_Req = w_rd;

    assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);

    always_comb begin
        w_in.vld  = iDisp_Req;
        w_in.rd   = w_rd;
        w_in.uf   = w_uf;
        w_in.view = r_sel;
        w_in.x    = r_x;
        w_in.y    = r_y;
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_pipe_busy = w_pipe_busy | r_pipe[i].vld;
        end
    end

    // -------------------------------------------------------------------------
    // FSM and pixel position
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_WAIT_FRAME;
            r_x     <= '0;
            r_y     <= '0;
            r_sel   <= VIEW_RGB;
        end else if (iFrame_Start) begin
            // Starts a frame from any state. An aborted frame's in-flight
            // pixels finish with the coordinates they already carry.
            r_state <= ST_ACTIVE;
            r_x     <= '0;
            r_y     <= '0;
            r_sel   <= iSelect;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (iDisp_Req) begin
                        if (w_last_pix) begin
                            r_x     <= '0;
                            r_y     <= '0;
                            r_state <= ST_DRAIN;
                        end else if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 10'd1;
                        end else begin
                            r_x <= r_x + 11'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    r_state <= ST_WAIT_FRAME;
                end
                default: begin
                    r_state <= ST_WAIT_FRAME;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Latency pipeline: tag of a request made in cycle t sits at stage
    // RD_LATENCY-1 in cycle t+RD_LATENCY, next to that request's FIFO data.
    // -------------------------------------------------------------------------
    // NOTE: the pipeline is a handful of flops, not a RAM, so clearing it on
    // reset is cheap and guarantees no stale pixel is emitted after reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out = r_pipe[RD_LATENCY-1];

    // -------------------------------------------------------------------------
    // Unpack and view selection
    // -------------------------------------------------------------------------
    assign w_r    = iRd2_data[9:2];
    assign w_g    = {iRd1_data[14:10], iRd2_data[14:12]};
    assign w_b    = iRd1_data[9:2];
    assign w_gray = {iRd1_data[15], iRd1_data[1:0], iRd2_data[15],
                     iRd2_data[11:10], iRd2_data[1:0]};

    always_comb begin
        w_pix_rgb  = 24'h000000;
        w_pix_gray = 8'h00;
        if (w_out.uf) begin
            // Underflow overrides the view and reports no gray.
            w_pix_rgb = UNDERFLOW_RGB;
        end else if (w_out.rd) begin
            w_pix_gray = w_gray;
            case (w_out.view)
                VIEW_RGB:     w_pix_rgb = {w_r, w_g, w_b};
                VIEW_GRAY:    w_pix_rgb = {w_gray, w_gray, w_gray};
                VIEW_OVERLAY: w_pix_rgb = (w_gray != 8'h00) ?
                                          {w_gray, w_gray, w_gray} :
                                          {w_r, w_g, w_b};
                default:      w_pix_rgb = UNDERFLOW_RGB;
            endcase
        end
        // Requests outside the active frame keep the black defaults.
    end

    // -------------------------------------------------------------------------
    // Output stage: colour and position hold their last value between pixels
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_pix_valid <= 1'b0;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_gray      <= '0;
            r_x_out     <= '0;
            r_y_out     <= '0;
        end else begin
            r_pix_valid <= w_out.vld;
            if (w_out.vld) begin
                {r_r, r_g, r_b} <= w_pix_rgb;
                r_gray          <= w_pix_gray;
                r_x_out         <= w_out.x;
                r_y_out         <= w_out.y;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Underflow reporting, aligned with the underflow pixel reaching the output
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_underflow <= 1'b0;
            r_uf_cnt    <= '0;
        end else begin
            // Setting has priority over the frame-start clear.
            if (w_out.vld && w_out.uf) begin
                r_underflow <= 1'b1;
            end else if (iFrame_Start) begin
                r_underflow <= 1'b0;
            end

            if (w_out.vld && w_out.uf && (r_uf_cnt != CNT_MAX)) begin
                r_uf_cnt <= r_uf_cnt + 16'd1;
            end
        end
    end

    assign oR             = r_r;
    assign oG             = r_g;
    assign oB             = r_b;
    assign oGray          = r_gray;
    assign oPix_Valid     = r_pix_valid;
    assign oX_Cont        = r_x_out;
    assign oY_Cont        = r_y_out;
    assign oUnderflow     = r_underflow;
    assign oUnderflow_Cnt = r_uf_cnt;

endmodule

// File: tb/tb_sdram_pixel_unpacker.sv
// -----------------------------------------------------------------------------
// tb_sdram_pixel_unpacker
//
// Drives sdram_pixel_unpacker with randomized pixel requests and FIFO states.
// A reference model built from the frame/position/view rules predicts every
// output cycle. FIFO words are produced by packing randomly chosen
// R/G/B/gray bytes in the write packer's layout. The expected pixel is
// therefore the original bytes put through the view rule.
// -----------------------------------------------------------------------------
module tb_sdram_pixel_unpacker;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          L    = 3;
    localparam logic [23:0] FILL = 24'hFF0000;

    logic        iClk         = 1'b0;
    logic        iRst         = 1'b1;
    logic        iFrame_Start = 1'b0;
    logic [1:0]  iSelect      = 2'd0;
    logic        iDisp_Req    = 1'b0;
    logic        iRd1_Empty   = 1'b0;
    logic        iRd2_Empty   = 1'b0;
    logic [15:0] iRd1_data    = 16'h0;
    logic [15:0] iRd2_data    = 16'h0;
    logic        oRd_Req;
    logic [7:0]  oR;
    logic [7:0]  oG;
    logic [7:0]  oB;
    logic [7:0]  oGray;
    logic        oPix_Valid;
    logic [10:0] oX_Cont;
    logic [9:0]  oY_Cont;
    logic        oUnderflow;
    logic [15:0] oUnderflow_Cnt;

    always #5 iClk = ~iClk;

    sdram_pixel_unpacker #(
        .H_ACTIVE      (H),
        .V_ACTIVE      (V),
        .RD_LATENCY    (L),
        .UNDERFLOW_RGB (FILL)
    ) dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iFrame_Start   (iFrame_Start),
        .iSelect        (iSelect),
        .iDisp_Req      (iDisp_Req),
        .iRd1_Empty     (iRd1_Empty),
        .iRd2_Empty     (iRd2_Empty),
        .iRd1_data      (iRd1_data),
        .iRd2_data      (iRd2_data),
        .oRd_Req        (oRd_Req),
        .oR             (oR),
        .oG             (oG),
        .oB             (oB),
        .oGray          (oGray),
        .oPix_Valid     (oPix_Valid),
        .oX_Cont        (oX_Cont),
        .oY_Cont        (oY_Cont),
        .oUnderflow     (oUnderflow),
        .oUnderflow_Cnt (oUnderflow_Cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected pixel, due in a given cycle
    typedef struct {
        int         due;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] gray;
        bit         uf;
        int         x;
        int         y;
    } pix_t;
    pix_t sb[$];

    // FIFO read history, indexed by cycle modulo 8
    bit          rd_hist [8];
    logic [15:0] w1_hist [8];
    logic [15:0] w2_hist [8];

    // Model state
    bit         m_started = 1'b0;
    int         m_idx     = 0;
    logic [1:0] m_view    = 2'd0;
    bit         m_uf      = 1'b0;
    int         m_cnt     = 0;
    int         m_lx      = 0;
    int         m_ly      = 0;
    int         gray_force = -1;

    // Write-packer layout: word1 {g7,G7:3,B,g6:5}, word2 {g4,G2:0,g3:2,R,g1:0}
    function automatic logic [31:0] pack_words(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b, input logic [7:0] gy);
        return {gy[7], g[7:3], b, gy[6:5], gy[4], g[2:0], gy[3:2], r, gy[1:0]};
    endfunction

    function automatic logic [23:0] view_rgb(input logic [1:0] view, input logic [7:0] r,
                                             input logic [7:0] g, input logic [7:0] b,
                                             input logic [7:0] gy);
        case (view)
            2'd0:    return {r, g, b};
            2'd1:    return {gy, gy, gy};
            2'd2:    return (gy != 8'h00) ? {gy, gy, gy} : {r, g, b};
            default: return FILL;
        endcase
    endfunction

    // Compare the registered outputs for the current cycle with the model
    task automatic monitor();
        pix_t p;
        bit   exp_v;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        checks++;
        if (oPix_Valid !== exp_v) begin
            errors++;
            $display("FAIL pix_valid cycle %0d: got %b expected %b", cyc, oPix_Valid, exp_v);
        end
        if (exp_v) begin
            p = sb.pop_front();
            checks++;
            if ({oR, oG, oB, oGray} !== {p.r, p.g, p.b, p.gray}) begin
                errors++;
                $display("FAIL pixel cycle %0d: got RGB=%h%h%h gray=%h expected RGB=%h%h%h gray=%h",
                         cyc, oR, oG, oB, oGray, p.r, p.g, p.b, p.gray);
            end
            m_lx = p.x;
            m_ly = p.y;
        end
        checks++;
        if (oX_Cont !== 11'(m_lx) || oY_Cont !== 10'(m_ly)) begin
            errors++;
            $display("FAIL position cycle %0d: got x=%0d y=%0d expected x=%0d y=%0d",
                     cyc, oX_Cont, oY_Cont, m_lx, m_ly);
        end
        checks++;
        if (oUnderflow !== m_uf) begin
            errors++;
            $display("FAIL underflow_flag cycle %0d: got %b expected %b", cyc, oUnderflow, m_uf);
        end
        checks++;
        if (oUnderflow_Cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL underflow_cnt cycle %0d: got %0d expected %0d", cyc, oUnderflow_Cnt, m_cnt);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, predict, advance the model
    task automatic step(input bit rst, input bit fs, input logic [1:0] sel,
                        input bit req, input bit e1, input bit e2);
        bit          active;
        bit          exp_rd;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [7:0]  gy;
        logic [31:0] w;
        pix_t        p;
        @(negedge iClk);
        cyc++;
        monitor();
        if (cyc >= L && rd_hist[(cyc - L) % 8]) begin
            iRd1_data = w1_hist[(cyc - L) % 8];
            iRd2_data = w2_hist[(cyc - L) % 8];
        end else begin
            iRd1_data = 16'($urandom);
            iRd2_data = 16'($urandom);
        end
        iRst         = rst;
        iFrame_Start = fs;
        iSelect      = sel;
        iDisp_Req    = req;
        iRd1_Empty   = e1;
        iRd2_Empty   = e2;

        active = !rst && m_started && (m_idx < H * V);
        exp_rd = active && req && !e1 && !e2;
        rd_hist[cyc % 8] = exp_rd;
        if (req && !rst) begin
            p.due = cyc + L + 1;
            p.x   = m_idx % H;
            p.y   = (m_idx / H) % V;
            p.uf  = active && !exp_rd;
            if (exp_rd) begin
                r  = 8'($urandom);
                g  = 8'($urandom);
                b  = 8'($urandom);
                gy = (gray_force >= 0) ? 8'(gray_force) : 8'($urandom);
                w  = pack_words(r, g, b, gy);
                w1_hist[cyc % 8] = w[31:16];
                w2_hist[cyc % 8] = w[15:0];
                {p.r, p.g, p.b} = view_rgb(m_view, r, g, b, gy);
                p.gray = gy;
            end else if (p.uf) begin
                {p.r, p.g, p.b} = FILL;
                p.gray = 8'h00;
            end else begin
                {p.r, p.g, p.b} = 24'h000000;
                p.gray = 8'h00;
            end
            sb.push_back(p);
        end

        #1;
        checks++;
        if (oRd_Req !== exp_rd) begin
            errors++;
            $display("FAIL rd_req cycle %0d: got %b expected %b", cyc, oRd_Req, exp_rd);
        end

        if (rst) begin
            sb.delete();
            m_started = 1'b0;
            m_idx     = 0;
            m_view    = 2'd0;
            m_uf      = 1'b0;
            m_cnt     = 0;
            m_lx      = 0;
            m_ly      = 0;
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc + 1 && sb[0].uf) begin
                m_uf = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end else if (fs) begin
                m_uf = 1'b0;
            end
            if (active && req) m_idx++;
            if (fs) begin
                m_started = 1'b1;
                m_idx     = 0;
                m_view    = sel;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic req_n(input int n);
        repeat (n) step(1'b0, 1'b0, 2'(($urandom)), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({oR, oG, oB, oGray} !== 32'h0 || oPix_Valid !== 1'b0 || oRd_Req !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got RGB=%h%h%h gray=%h valid=%b rd=%b expected all 0",
                     oR, oG, oB, oGray, oPix_Valid, oRd_Req);
        end
    endtask

    task automatic test_rgb_view();
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        req_n(4);
        idle(L + 2);
        checks++;
        if (oX_Cont !== 11'd3 || oY_Cont !== 10'd0) begin
            errors++;
            $display("FAIL rgb_view_position: got x=%0d y=%0d expected x=3 y=0", oX_Cont, oY_Cont);
        end
    endtask

    task automatic test_gray_views();
        gray_force = 8'h5A;
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        req_n(3);
        idle(L + 1);
        checks++;
        if ({oR, oG, oB} !== 24'h5A5A5A) begin
            errors++;
            $display("FAIL gray_view: got RGB=%h%h%h expected 5A5A5A", oR, oG, oB);
        end
        gray_force = 0;
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        req_n(3);
        gray_force = -1;
        req_n(3);
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        req_n(2);
        idle(L + 2);
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        req_n(2);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        req_n(1);
        idle(L + 2);
        checks++;
        if (oUnderflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: got %b expected 1", oUnderflow);
        end
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (oUnderflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b expected 0", oUnderflow);
        end
    endtask

    task automatic test_full_frame();
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        req_n(H * V);
        req_n(2);
        idle(L + 3);
        req_n(1);
        idle(L + 2);
    endtask

    task automatic test_select_latch();
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 2'($urandom), 1'b1, 1'b0, 1'b0);
        idle(L + 2);
    endtask

    task automatic test_restart();
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        req_n(5);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        req_n(4);
        idle(L + 2);
        checks++;
        if (oX_Cont !== 11'd3 || oY_Cont !== 10'd0) begin
            errors++;
            $display("FAIL restart_position: got x=%0d y=%0d expected x=3 y=0", oX_Cont, oY_Cont);
        end
    endtask

    task automatic test_reset_mid_burst();
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        req_n(3);
        step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(L + 3);
        req_n(2);
        idle(L + 2);
        checks++;
        if (oX_Cont !== 11'd0 || oY_Cont !== 10'd0 || {oR, oG, oB} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_burst: got x=%0d y=%0d RGB=%h%h%h expected 0 0 000000",
                     oX_Cont, oY_Cont, oR, oG, oB);
        end
    endtask

    task automatic test_back_to_back();
        bit fs;
        step(1'b0, 1'b1, 2'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (300) begin
            fs = ($urandom % 40) == 0;
            step(1'b0, fs, 2'($urandom), !fs && (($urandom % 10) < 8),
                 ($urandom % 12) == 0, ($urandom % 12) == 0);
        end
        idle(L + 2);
    endtask

    task automatic test_saturation();
        repeat (2049) begin
            step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
            repeat (H * V) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        idle(L + 3);
        checks++;
        if (oUnderflow_Cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL underflow_saturation: got %h expected FFFF", oUnderflow_Cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rgb_view();
        test_gray_views();
        test_underflow();
        test_full_frame();
        test_select_latch();
        test_restart();
        test_reset_mid_burst();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
